// File: rtl/enemy_hit_tracker.sv
// ---------------------------------------------------------------------------
// enemy_hit_tracker
//   Runs the player's single upward bullet against the enemy formation.
//   It keeps a per-enemy alive bitmap, detects bullet/enemy collisions on game
//   ticks, clears enemies that are hit, and keeps a saturating kill score.
//
//   Optional feature macro: SCORE_BCD_EN
//     defined   -> score is two BCD digits ([7:4] tens, [3:0] units) and
//                  saturates at 8'h99
//     undefined -> score is binary and saturates at 255
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous reset, active low
//   tick         in   one-cycle game-step strobe
//   fire         in   launch request, sampled every clk
//   shooterX     in   player X, captured at launch
//   enemyX/Y     in   formation origin (top-left of cell row0/col0)
//   endgame      in   freezes all state while high
//   bulletX/Y    out  bullet position
//   bulletActive out  bullet in flight
//   aliveMask    out  bit (r*COLS+c) set = enemy r,c alive
//   hitPulse     out  one-cycle strobe on a kill
//   score        out  kill count
//   allDead      out  registered aliveMask==0
// ---------------------------------------------------------------------------
module enemy_hit_tracker #(
    parameter int COLS         = 4,
    parameter int ROWS         = 2,
    parameter int CELL_LOG2    = 5,
    parameter int SPRITE_W     = 24,
    parameter int SPRITE_H     = 24,
    parameter int BULLET_Y0    = 440,
    parameter int BULLET_SPEED = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 fire,
    input  logic [9:0]           shooterX,
    input  logic [9:0]           enemyX,
    input  logic [9:0]           enemyY,
    input  logic                 endgame,
    output logic [9:0]           bulletX,
    output logic [9:0]           bulletY,
    output logic                 bulletActive,
    output logic [ROWS*COLS-1:0] aliveMask,
    output logic                 hitPulse,
    output logic [7:0]           score,
    output logic                 allDead
);

    localparam int N    = ROWS * COLS;
    localparam int IDXW = 10 - CELL_LOG2;

    localparam logic [9:0]           Y0    = BULLET_Y0[9:0];
    localparam logic [9:0]           SPEED = BULLET_SPEED[9:0];
    localparam logic [CELL_LOG2-1:0] SPR_W = SPRITE_W[CELL_LOG2-1:0];
    localparam logic [CELL_LOG2-1:0] SPR_H = SPRITE_H[CELL_LOG2-1:0];

    typedef enum logic {IDLE, FLY} state_t;

    state_t         state_q, state_d;
    logic [9:0]     bx_q, bx_d, by_q, by_d;
    logic [N-1:0]   alive_q, alive_d;
    logic           hit_q, hit_d;
    logic [7:0]     score_q, score_d;
    logic           dead_q, dead_d;

    // Collision detect on the registered bullet against the live formation.
    logic [9:0]      dx, dy;
    logic [IDXW-1:0] col, row;
    logic            in_front, in_sprite;
    logic [N-1:0]    cell_hit;
    logic            hit;

    assign dx        = bx_q - enemyX;
    assign dy        = by_q - enemyY;
    assign col       = dx[9:CELL_LOG2];
    assign row       = dy[9:CELL_LOG2];
    // Subtractions only mean something when the bullet is right/below origin.
    assign in_front  = (bx_q >= enemyX) && (by_q >= enemyY);
    // Gaps between sprites inside a cell are not hittable.
    assign in_sprite = (dx[CELL_LOG2-1:0] < SPR_W) && (dy[CELL_LOG2-1:0] < SPR_H);

    // One-hot over cells; dead cells never match so the bullet flies through.
    always_comb begin
        cell_hit = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cell_hit[r*COLS+c] = in_front && in_sprite &&
                                     (row == IDXW'(r)) && (col == IDXW'(c)) &&
                                     alive_q[r*COLS+c];
            end
        end
    end

    assign hit = |cell_hit;

    // Saturating score increment.
    function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
        if (s == 8'h99)          return s;
        else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
        else                     return {s[7:4], s[3:0] + 4'd1};
`else
        if (s == 8'hFF)          return s;
        else                     return s + 8'd1;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        alive_d = alive_q;
        score_d = score_q;
        hit_d   = 1'b0;
        if (!endgame) begin
            case (state_q)
                IDLE: begin
                    // A tick in the launch cycle does not move the new bullet.
                    if (fire && !dead_q) begin
                        bx_d    = shooterX;
                        by_d    = Y0;
                        state_d = FLY;
                    end
                end
                FLY: begin
                    if (tick) begin
                        if (hit) begin
                            alive_d = alive_q & ~cell_hit;
                            hit_d   = 1'b1;
                            score_d = score_inc(score_q);
                            state_d = IDLE;
                        end else if (by_q < SPEED) begin
                            state_d = IDLE;
                        end else begin
                            by_d = by_q - SPEED;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        dead_d = ~|alive_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bx_q    <= '0;
            by_q    <= '0;
            alive_q <= '1;
            hit_q   <= 1'b0;
            score_q <= '0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            alive_q <= alive_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            dead_q  <= dead_d;
        end
    end

    assign bulletX      = bx_q;
    assign bulletY      = by_q;
    assign bulletActive = (state_q == FLY);
    assign aliveMask    = alive_q;
    assign hitPulse     = hit_q && !endgame;
    assign score        = score_q;
    assign allDead      = dead_q;

endmodule
